// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - initiator-side request/response front end for a 1-cycle registered single-port memory
//
// Accepts valid/ready read/write requests and drives the memory port combinationally
// (zero added latency). Read data returns one cycle after issue and is pushed into an
// in-order response FIFO. A read is only accepted when a FIFO slot is guaranteed, so
// returning data can never be dropped.
//
// Ports:
//   iw_clk, iw_rst                     clock, asynchronous active-high reset
//   iw_req_valid/ow_req_ready          request handshake
//   iw_req_we/iw_req_addr/iw_req_wdata request attributes (1=write)
//   ow_mem_we/ow_mem_addr/ow_mem_wdata memory drive
//   iw_mem_rdata                       memory registered read data
//   ow_rsp_valid/ow_rsp_data           response FIFO head
//   iw_rsp_ready                       response pop
//   ow_outstanding                     buffered + in-flight reads
module mem_req_ctrl #(
    parameter int RSP_DEPTH = 2,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 24
) (
    input  logic                         iw_clk,
    input  logic                         iw_rst,
    input  logic                         iw_req_valid,
    output logic                         ow_req_ready,
    input  logic                         iw_req_we,
    input  logic [ADDR_W-1:0]            iw_req_addr,
    input  logic [DATA_W-1:0]            iw_req_wdata,
    output logic                         ow_mem_we,
    output logic [ADDR_W-1:0]            ow_mem_addr,
    output logic [DATA_W-1:0]            ow_mem_wdata,
    input  logic [DATA_W-1:0]            iw_mem_rdata,
    output logic                         ow_rsp_valid,
    output logic [DATA_W-1:0]            ow_rsp_data,
    input  logic                         iw_rsp_ready,
    output logic [$clog2(RSP_DEPTH):0]   ow_outstanding
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
    localparam logic [CW:0]   DEPTH_CW = (CW + 1)'(RSP_DEPTH);

    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] fifo_q [RSP_DEPTH];

    logic              pop;
    logic              push;
    logic              acc;
    logic              credit_ok;
    logic [CW:0]       committed;

    assign ow_rsp_valid = !iw_rst && (count_q != '0);
    assign pop          = ow_rsp_valid & iw_rsp_ready;
    // A read issued in cycle t lands in the FIFO at the end of t+1, so the slot is
    // reserved now: entries held plus the read in flight, less the one leaving.
    // pop implies count_q >= 1, so this never underflows.
    assign committed    = {1'b0, count_q} + {{CW{1'b0}}, rd_pend_q} - {{CW{1'b0}}, pop};
    assign credit_ok    = committed < DEPTH_CW;
    assign ow_req_ready = !iw_rst & (iw_req_we | credit_ok);
    assign acc          = iw_req_valid & ow_req_ready;
    assign push         = rd_pend_q;

    assign ow_mem_we      = acc & iw_req_we;
    // Hold the last issued address while idle so the address bus does not toggle.
    assign ow_mem_addr    = acc ? iw_req_addr : last_addr_q;
    assign ow_mem_wdata   = iw_req_wdata;
    assign ow_rsp_data    = fifo_q[rd_ptr_q];
    assign ow_outstanding = count_q + {{PW{1'b0}}, rd_pend_q};

    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_pend_d   = acc & ~iw_req_we;
        last_addr_d = last_addr_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (acc) begin
            last_addr_d = iw_req_addr;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_pend_q   <= 1'b0;
            last_addr_q <= '0;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_pend_q   <= rd_pend_d;
            last_addr_q <= last_addr_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge iw_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= iw_mem_rdata;
        end
    end

    // Credit accounting must make an overflowing push impossible.
    always @(posedge iw_clk) begin
        if (!iw_rst && push) begin
            assert (count_q < DEPTH_C);
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed self-checking bench for mem_req_ctrl
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [11:0] req_addr = '0;
    logic [23:0] req_wdata = '0;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata = '0;
    logic        rsp_valid;
    logic [23:0] rsp_data;
    logic        rsp_ready = 1'b0;
    logic [1:0]  outstanding;

    int n_cmp = 0;
    int n_err = 0;

    // Memory model: write-first, 1-cycle registered read. Addresses 0..7 hold
    // 0x100000+addr until written; everything else reads 0 until written.
    logic [23:0] mem_arr [4096];
    bit          written [4096];

    function automatic logic [23:0] mem_value(input logic [11:0] a);
        if (written[a]) return mem_arr[a];
        if (a < 12'd8) return 24'h100000 + 24'(a);
        return 24'h0;
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            mem_arr[mem_addr] <= mem_wdata;
            written[mem_addr] <= 1'b1;
            mem_rdata         <= mem_wdata;
        end else begin
            mem_rdata <= mem_value(mem_addr);
        end
    end

    always #5 clk = ~clk;

    mem_req_ctrl #(
        .RSP_DEPTH (2),
        .ADDR_W    (12),
        .DATA_W    (24)
    ) dut (
        .iw_clk         (clk),
        .iw_rst         (rst),
        .iw_req_valid   (req_valid),
        .ow_req_ready   (req_ready),
        .iw_req_we      (req_we),
        .iw_req_addr    (req_addr),
        .iw_req_wdata   (req_wdata),
        .ow_mem_we      (mem_we),
        .ow_mem_addr    (mem_addr),
        .ow_mem_wdata   (mem_wdata),
        .iw_mem_rdata   (mem_rdata),
        .ow_rsp_valid   (rsp_valid),
        .ow_rsp_data    (rsp_data),
        .iw_rsp_ready   (rsp_ready),
        .ow_outstanding (outstanding)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; checks follow 1 time unit later.
    task automatic drv(input logic v, input logic we, input logic [11:0] a,
                       input logic [23:0] d, input logic rr);
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = rr;
        #1;
    endtask

    initial begin
        // Reset state
        drv(0, 0, 12'h000, 24'h0, 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        drv(1, 1, 12'h3ff, 24'h777777, 1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        drv(0, 0, 12'h000, 24'h0, 0);
        rst = 1'b0;

        // 1: write then read same address
        drv(1, 1, 12'h010, 24'h123456, 0);
        chk("t1_wr_ready", 32'(req_ready), 32'd1);
        chk("t1_mem_we", 32'(mem_we), 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h010);
        chk("t1_mem_wdata", 32'(mem_wdata), 32'h123456);
        drv(1, 0, 12'h010, 24'h0, 0);
        chk("t1_rd_ready", 32'(req_ready), 32'd1);
        chk("t1_rd_mem_we", 32'(mem_we), 32'd0);
        drv(0, 0, 12'h3aa, 24'h0, 0);
        chk("t1_hold_addr", 32'(mem_addr), 32'h010);
        chk("t1_lat1_valid", 32'(rsp_valid), 32'd0);
        chk("t1_lat1_outst", 32'(outstanding), 32'd1);
        drv(0, 0, 12'h3aa, 24'h0, 0);
        chk("t1_lat2_valid", 32'(rsp_valid), 32'd1);
        chk("t1_lat2_data", 32'(rsp_data), 32'h123456);
        chk("t1_lat2_outst", 32'(outstanding), 32'd1);
        drv(0, 0, 12'h3aa, 24'h0, 1);
        chk("t1_pop_valid", 32'(rsp_valid), 32'd1);
        drv(0, 0, 12'h3aa, 24'h0, 0);
        chk("t1_empty", 32'(rsp_valid), 32'd0);
        chk("t1_empty_outst", 32'(outstanding), 32'd0);

        // 2: back-to-back reads with consumer always ready
        for (int i = 0; i < 10; i++) begin
            drv(i < 8, 0, 12'(i), 24'h0, 1);
            if (i < 8) chk($sformatf("t2_ready_%0d", i), 32'(req_ready), 32'd1);
            if (i >= 2) begin
                chk($sformatf("t2_valid_%0d", i - 2), 32'(rsp_valid), 32'd1);
                chk($sformatf("t2_data_%0d", i - 2), 32'(rsp_data), 32'h100000 + 32'(i - 2));
            end
        end
        drv(0, 0, 12'h0, 24'h0, 1);
        chk("t2_end_valid", 32'(rsp_valid), 32'd0);
        chk("t2_end_outst", 32'(outstanding), 32'd0);

        // 3: backpressure - credit exhausts, writes still flow, drain resumes reads
        drv(1, 0, 12'h000, 24'h0, 0);
        chk("t3_rd0_ready", 32'(req_ready), 32'd1);
        drv(1, 0, 12'h001, 24'h0, 0);
        chk("t3_rd1_ready", 32'(req_ready), 32'd1);
        drv(1, 0, 12'h002, 24'h0, 0);
        chk("t3_stall_a", 32'(req_ready), 32'd0);
        chk("t3_stall_a_outst", 32'(outstanding), 32'd2);
        drv(1, 0, 12'h002, 24'h0, 0);
        chk("t3_stall_b", 32'(req_ready), 32'd0);
        chk("t3_stall_b_outst", 32'(outstanding), 32'd2);
        chk("t3_stall_b_data", 32'(rsp_data), 32'h100000);
        drv(1, 1, 12'h030, 24'h555555, 0);
        chk("t3_wr_ready", 32'(req_ready), 32'd1);
        chk("t3_wr_mem_we", 32'(mem_we), 32'd1);
        drv(1, 0, 12'h002, 24'h0, 1);
        chk("t3_resume_ready", 32'(req_ready), 32'd1);
        chk("t3_d0", 32'(rsp_data), 32'h100000);
        drv(1, 0, 12'h003, 24'h0, 1);
        chk("t3_rd3_ready", 32'(req_ready), 32'd1);
        chk("t3_d1", 32'(rsp_data), 32'h100001);
        drv(0, 0, 12'h000, 24'h0, 1);
        chk("t3_d2_valid", 32'(rsp_valid), 32'd1);
        chk("t3_d2", 32'(rsp_data), 32'h100002);
        drv(0, 0, 12'h000, 24'h0, 1);
        chk("t3_d3", 32'(rsp_data), 32'h100003);
        drv(0, 0, 12'h000, 24'h0, 1);
        chk("t3_end_valid", 32'(rsp_valid), 32'd0);
        chk("t3_end_outst", 32'(outstanding), 32'd0);

        // 4: async reset with one buffered and one in-flight read
        drv(1, 0, 12'h004, 24'h0, 0);
        drv(1, 0, 12'h005, 24'h0, 0);
        drv(1, 0, 12'h006, 24'h0, 0);
        chk("t4_pre_outst", 32'(outstanding), 32'd2);
        chk("t4_pre_valid", 32'(rsp_valid), 32'd1);
        chk("t4_pre_data", 32'(rsp_data), 32'h100004);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_async_valid", 32'(rsp_valid), 32'd0);
        chk("t4_async_outst", 32'(outstanding), 32'd0);
        chk("t4_async_ready", 32'(req_ready), 32'd0);
        drv(0, 0, 12'h000, 24'h0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 12'h000, 24'h0, 1);
            chk($sformatf("t4_post_valid_%0d", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("t4_post_outst_%0d", i), 32'(outstanding), 32'd0);
        end

        // 5: unwritten address and write-then-read ordering
        drv(1, 0, 12'hfff, 24'h0, 1);
        chk("t5_rdfff_ready", 32'(req_ready), 32'd1);
        drv(1, 1, 12'h020, 24'habcdef, 1);
        chk("t5_wr_mem_we", 32'(mem_we), 32'd1);
        drv(1, 0, 12'h020, 24'h0, 1);
        chk("t5_rd020_ready", 32'(req_ready), 32'd1);
        chk("t5_fff_valid", 32'(rsp_valid), 32'd1);
        chk("t5_fff_data", 32'(rsp_data), 32'h000000);
        drv(0, 0, 12'h000, 24'h0, 1);
        chk("t5_gap_valid", 32'(rsp_valid), 32'd0);
        drv(0, 0, 12'h000, 24'h0, 1);
        chk("t5_020_valid", 32'(rsp_valid), 32'd1);
        chk("t5_020_data", 32'(rsp_data), 32'habcdef);
        drv(0, 0, 12'h000, 24'h0, 1);
        chk("t5_end_outst", 32'(outstanding), 32'd0);

        // 6: full FIFO, pop and accept in the same cycle
        drv(1, 0, 12'h000, 24'h0, 0);
        drv(1, 0, 12'h001, 24'h0, 0);
        drv(1, 0, 12'h002, 24'h0, 0);
        chk("t6_stall_a", 32'(req_ready), 32'd0);
        drv(1, 0, 12'h002, 24'h0, 0);
        chk("t6_full_ready", 32'(req_ready), 32'd0);
        chk("t6_full_outst", 32'(outstanding), 32'd2);
        drv(1, 0, 12'h002, 24'h0, 1);
        chk("t6_swap_ready", 32'(req_ready), 32'd1);
        chk("t6_swap_data", 32'(rsp_data), 32'h100000);
        drv(1, 0, 12'h003, 24'h0, 0);
        chk("t6_after_ready", 32'(req_ready), 32'd0);
        chk("t6_after_outst", 32'(outstanding), 32'd2);
        chk("t6_after_data", 32'(rsp_data), 32'h100001);
        drv(1, 0, 12'h003, 24'h0, 0);
        chk("t6_refull_outst", 32'(outstanding), 32'd2);
        chk("t6_refull_ready", 32'(req_ready), 32'd0);
        drv(1, 0, 12'h003, 24'h0, 1);
        chk("t6_swap2_ready", 32'(req_ready), 32'd1);
        chk("t6_d1", 32'(rsp_data), 32'h100001);
        drv(0, 0, 12'h000, 24'h0, 1);
        chk("t6_d2", 32'(rsp_data), 32'h100002);
        drv(0, 0, 12'h000, 24'h0, 1);
        chk("t6_d3_valid", 32'(rsp_valid), 32'd1);
        chk("t6_d3", 32'(rsp_data), 32'h100003);
        drv(0, 0, 12'h000, 24'h0, 1);
        chk("t6_end_valid", 32'(rsp_valid), 32'd0);
        chk("t6_end_outst", 32'(outstanding), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
